// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared defaults and one-hot/index helpers for the register-file arbiter
//
// Purpose : default sizing for regs_arbiter and conversion helpers between
//           one-hot grant vectors and binary requester indices.
// Contents: N_REQ_DEF, AW_DEF, DW_DEF, MAX_REQ, idx_to_onehot(), onehot_to_idx()

package regs_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int AW_DEF    = 4;
    localparam int DW_DEF    = 16;

    // Helpers operate on a fixed 32-bit container; callers cast to their width.
    localparam int MAX_REQ   = 32;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input int unsigned idx);
        logic [MAX_REQ-1:0] oh;
        oh = '0;
        oh[idx[4:0]] = 1'b1;
        return oh;
    endfunction

    // OR-encoder: the input is one-hot, so OR-ing the set indices yields the
    // index without a priority chain.
    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with a rotating priority pointer
//
// Purpose : grants the first requesting index at or after the pointer
//           (modulo N); the pointer moves just past the winner on a grant
//           and holds when nothing is requested.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset (pointer -> 0)
//           req   - per-index request
//           gnt   - one-hot grant, combinational from req and pointer

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    // N is a power of two, so IW-bit addition wraps modulo N for free.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IW'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                ptr_d     = cand + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regs_arbiter.sv
// rtl/regs_arbiter.sv - shares the register file read-port pair and write port among requesters
//
// Purpose : two independent round-robin arbiters (read, write), payload muxes
//           onto the register-file ports, and a one-cycle response tag for reads.
// Ports   : clk, rst_n                 - clock, asynchronous active-low reset
//           rd_req/rd_addr0/rd_addr1   - packed per-requester read requests
//           rd_gnt                     - one-hot read grant (combinational)
//           rd_rsp_valid               - one-hot, one cycle after rd_gnt
//           rd_rsp_data0/1             - shared read data (pass-through)
//           wr_req/wr_addr/wr_data     - packed per-requester write requests
//           wr_gnt                     - one-hot write grant (combinational)
//           rf_raddr0/1, rf_rdata0/1   - register-file read ports
//           rf_wen/rf_waddr/rf_wdata   - register-file write port

module regs_arbiter
    import regs_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [N_REQ-1:0]    rd_req,
    input  logic [N_REQ*AW-1:0] rd_addr0,
    input  logic [N_REQ*AW-1:0] rd_addr1,
    output logic [N_REQ-1:0]    rd_gnt,
    output logic [N_REQ-1:0]    rd_rsp_valid,
    output logic [DW-1:0]       rd_rsp_data0,
    output logic [DW-1:0]       rd_rsp_data1,

    input  logic [N_REQ-1:0]    wr_req,
    input  logic [N_REQ*AW-1:0] wr_addr,
    input  logic [N_REQ*DW-1:0] wr_data,
    output logic [N_REQ-1:0]    wr_gnt,

    output logic [AW-1:0]       rf_raddr0,
    output logic [AW-1:0]       rf_raddr1,
    input  logic [DW-1:0]       rf_rdata0,
    input  logic [DW-1:0]       rf_rdata1,
    output logic                rf_wen,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          rd_any;
    logic          wr_any;

    logic          rsp_vld_q;
    logic          rsp_vld_d;
    logic [IW-1:0] rsp_id_q;
    logic [IW-1:0] rsp_id_d;

    rr_arbiter #(.N(N_REQ)) u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    rr_arbiter #(.N(N_REQ)) u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    always_comb begin
        rd_any = |rd_gnt;
        wr_any = |wr_gnt;
        rd_idx = IW'(onehot_to_idx(32'(rd_gnt)));
        wr_idx = IW'(onehot_to_idx(32'(wr_gnt)));
    end

    // Read port mux: idle ports present address 0.
    always_comb begin
        rf_raddr0 = '0;
        rf_raddr1 = '0;
        if (rd_any) begin
            rf_raddr0 = rd_addr0[rd_idx*AW +: AW];
            rf_raddr1 = rd_addr1[rd_idx*AW +: AW];
        end
    end

    // Write port mux: idle port presents zero address/data with wen low.
    always_comb begin
        rf_wen   = wr_any;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wr_any) begin
            rf_waddr = wr_addr[wr_idx*AW +: AW];
            rf_wdata = wr_data[wr_idx*DW +: DW];
        end
    end

    // The register file registers the read address on the grant edge, so the
    // data shows up on rf_rdata exactly when this tag becomes valid.
    always_comb begin
        rsp_vld_d = rd_any;
        rsp_id_d  = rd_any ? rd_idx : rsp_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    always_comb begin
        rd_rsp_valid = rsp_vld_q ? N_REQ'(idx_to_onehot(32'(rsp_id_q))) : '0;
        rd_rsp_data0 = rf_rdata0;
        rd_rsp_data1 = rf_rdata1;
    end

endmodule

// File: tb/tb_regs_arbiter.sv
// tb/tb_regs_arbiter.sv - directed self-checking bench for regs_arbiter with a behavioural register file

module tb_regs_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    rd_req;
    logic [N*AW-1:0] rd_addr0;
    logic [N*AW-1:0] rd_addr1;
    logic [N-1:0]    rd_gnt;
    logic [N-1:0]    rd_rsp_valid;
    logic [DW-1:0]   rd_rsp_data0;
    logic [DW-1:0]   rd_rsp_data1;
    logic [N-1:0]    wr_req;
    logic [N*AW-1:0] wr_addr;
    logic [N*DW-1:0] wr_data;
    logic [N-1:0]    wr_gnt;
    logic [AW-1:0]   rf_raddr0;
    logic [AW-1:0]   rf_raddr1;
    logic [DW-1:0]   rf_rdata0;
    logic [DW-1:0]   rf_rdata1;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;

    // Behavioural 16x16 register file: read addresses latched on the same
    // edge as the write, so a same-cycle read sees the new value.
    logic [DW-1:0]   mem [16];
    logic [AW-1:0]   ra0_q = '0;
    logic [AW-1:0]   ra1_q = '0;
    logic            pl_en = 1'b0;
    logic [AW-1:0]   pl_addr = '0;
    logic [DW-1:0]   pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)  mem[pl_addr] <= pl_data;
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
        ra0_q <= rf_raddr0;
        ra1_q <= rf_raddr1;
    end

    assign rf_rdata0 = mem[ra0_q];
    assign rf_rdata1 = mem[ra1_q];

    regs_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req       (rd_req),
        .rd_addr0     (rd_addr0),
        .rd_addr1     (rd_addr1),
        .rd_gnt       (rd_gnt),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data0 (rd_rsp_data0),
        .rd_rsp_data1 (rd_rsp_data1),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .rf_raddr0    (rf_raddr0),
        .rf_raddr1    (rf_raddr1),
        .rf_rdata0    (rf_rdata0),
        .rf_rdata1    (rf_rdata1),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [N-1:0] seq [5];
    logic [N-1:0] prev;
    int           waited;

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;
        rst_n    = 1'b0;
        rd_req   = '0;
        rd_addr0 = '0;
        rd_addr1 = '0;
        wr_req   = '0;
        wr_addr  = '0;
        wr_data  = '0;

        // 1: reset and first grants
        rd_req = 4'hF;
        next_cycle();
        next_cycle();
        check("rst_rsp_valid", 32'(rd_rsp_valid), 32'h0);
        check("rst_rd_gnt", 32'(rd_gnt), 32'h1);
        rst_n = 1'b1;
        #1;
        prev = '0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_gnt_%0d", i), 32'(rd_gnt), 32'(seq[i]));
            check($sformatf("rr_rsp_%0d", i), 32'(rd_rsp_valid), 32'(prev));
            prev = seq[i];
            next_cycle();
        end
        rd_req = '0;
        #1;
        check("rr_rsp_last", 32'(rd_rsp_valid), 32'h1);
        check("idle_rd_gnt", 32'(rd_gnt), 32'h0);

        // preload r5, r9
        pl_en = 1'b1; pl_addr = 4'd5; pl_data = 16'h1234;
        next_cycle();
        pl_addr = 4'd9; pl_data = 16'hBEEF;
        next_cycle();
        pl_en = 1'b0;
        next_cycle();
        check("idle_rsp_valid", 32'(rd_rsp_valid), 32'h0);

        // 2: single read by requester 2 (rd_ptr = 1)
        rd_req = 4'b0100;
        rd_addr0[2*AW +: AW] = 4'd5;
        rd_addr1[2*AW +: AW] = 4'd9;
        #1;
        check("rd2_gnt", 32'(rd_gnt), 32'h4);
        check("rd2_raddr0", 32'(rf_raddr0), 32'd5);
        check("rd2_raddr1", 32'(rf_raddr1), 32'd9);
        next_cycle();
        rd_req = '0;
        #1;
        check("rd2_rsp_valid", 32'(rd_rsp_valid), 32'h4);
        check("rd2_data0", 32'(rd_rsp_data0), 32'h1234);
        check("rd2_data1", 32'(rd_rsp_data1), 32'hBEEF);
        check("idle_raddr0", 32'(rf_raddr0), 32'h0);

        // 3: write arbitration, requesters 1 and 3 to r7 (wr_ptr = 0)
        wr_req = 4'b1010;
        wr_addr[1*AW +: AW] = 4'd7; wr_data[1*DW +: DW] = 16'h0011;
        wr_addr[3*AW +: AW] = 4'd7; wr_data[3*DW +: DW] = 16'h0033;
        #1;
        check("wr_first_gnt", 32'(wr_gnt), 32'h2);
        check("wr_first_wen", 32'(rf_wen), 32'h1);
        check("wr_first_waddr", 32'(rf_waddr), 32'd7);
        check("wr_first_wdata", 32'(rf_wdata), 32'h0011);
        next_cycle();
        wr_req = 4'b1000;
        #1;
        check("wr_second_gnt", 32'(wr_gnt), 32'h8);
        check("wr_second_wdata", 32'(rf_wdata), 32'h0033);
        next_cycle();
        wr_req = '0;
        #1;
        check("wr_idle_wen", 32'(rf_wen), 32'h0);
        check("wr_idle_wdata", 32'(rf_wdata), 32'h0);
        // read r7 by requester 0 (rd_ptr = 3, wraps to 0)
        rd_req = 4'b0001;
        rd_addr0[0 +: AW] = 4'd7;
        rd_addr1[0 +: AW] = 4'd5;
        #1;
        check("rd7_gnt", 32'(rd_gnt), 32'h1);
        next_cycle();
        rd_req = '0;
        #1;
        check("rd7_rsp_valid", 32'(rd_rsp_valid), 32'h1);
        check("rd7_data0", 32'(rd_rsp_data0), 32'h0033);
        check("rd7_data1", 32'(rd_rsp_data1), 32'h1234);

        // 4: same-cycle write r4 by req 0 and read r4 by req 1
        wr_req = 4'b0001;
        wr_addr[0 +: AW] = 4'd4; wr_data[0 +: DW] = 16'hA5A5;
        rd_req = 4'b0010;
        rd_addr0[1*AW +: AW] = 4'd4;
        rd_addr1[1*AW +: AW] = 4'd4;
        #1;
        check("rw_wr_gnt", 32'(wr_gnt), 32'h1);
        check("rw_rd_gnt", 32'(rd_gnt), 32'h2);
        next_cycle();
        wr_req = '0;
        rd_req = '0;
        #1;
        check("rw_rsp_valid", 32'(rd_rsp_valid), 32'h2);
        check("rw_data0", 32'(rd_rsp_data0), 32'hA5A5);
        check("rw_data1", 32'(rd_rsp_data1), 32'hA5A5);

        // 5: fairness, rd_ptr = 2; requester 0 holds, requester 3 pulses
        rd_req = 4'b0001;
        #1;
        check("fair_c0_gnt", 32'(rd_gnt), 32'h1);
        next_cycle();
        rd_req = 4'b1001;
        #1;
        waited = 0;
        while (!rd_gnt[3] && waited < 3) begin
            next_cycle();
            waited++;
        end
        check("fair_r3_wait", 32'(waited), 32'd0);
        check("fair_c1_gnt", 32'(rd_gnt), 32'h8);
        next_cycle();
        rd_req = 4'b0001;
        #1;
        check("fair_c2_gnt", 32'(rd_gnt), 32'h1);
        check("fair_c2_rsp", 32'(rd_rsp_valid), 32'h8);

        // 6: mid-operation reset (rd_ptr = 1, wr_ptr = 1)
        next_cycle();
        rd_req = 4'b0100;
        #1;
        check("mrst_gnt", 32'(rd_gnt), 32'h4);
        next_cycle();
        rd_req = '0;
        #1;
        check("mrst_rsp_before", 32'(rd_rsp_valid), 32'h4);
        rst_n = 1'b0;
        #1;
        check("mrst_rsp_dropped", 32'(rd_rsp_valid), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        rd_req = 4'hF;
        wr_req = 4'hF;
        #1;
        check("mrst_rd_ptr0", 32'(rd_gnt), 32'h1);
        check("mrst_wr_ptr0", 32'(wr_gnt), 32'h1);
        next_cycle();
        check("mrst_rd_next", 32'(rd_gnt), 32'h2);
        check("mrst_wr_next", 32'(wr_gnt), 32'h2);
        check("mrst_rsp_next", 32'(rd_rsp_valid), 32'h1);
        rd_req = '0;
        wr_req = '0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regs_arbiter.md
# regs_arbiter

Shares the 16×16 register file between `N_REQ` requesters (cores/threads), using independent round-robin arbitration for the read-port pair and the single write port.
- A granted read uses both register-file read ports in the grant cycle. The data returns exactly one cycle later, tagged to the winning requester.
- A granted write drives the register-file write port in the grant cycle.
- The block sits between the requesters' issue/writeback stages and `regs`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2, power of two).
- `AW`, 4: register address width.
- `DW`, 16: register data width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_req`  in  N_REQ  per-requester read request.
- `rd_addr0`, `rd_addr1`  in  N_REQ*AW  packed read addresses; requester i occupies bits [i*AW +: AW].
- `rd_gnt`  out  N_REQ  one-hot read grant, same cycle as request.
- `rd_rsp_valid`  out  N_REQ  one-hot; read data valid for requester i.
- `rd_rsp_data0`, `rd_rsp_data1`  out  DW  shared read response data.
- `wr_req`  in  N_REQ  per-requester write request.
- `wr_addr`  in  N_REQ*AW  packed write addresses.
- `wr_data`  in  N_REQ*DW  packed write data.
- `wr_gnt`  out  N_REQ  one-hot write grant.
- `rf_raddr0`, `rf_raddr1`  out  AW  to register-file read address inputs (registered inside the register file).
- `rf_rdata0`, `rf_rdata1`  in  DW  from register file.
- `rf_wen`  out  1  register-file write enable.
- `rf_waddr`  out  AW  register-file write address.
- `rf_wdata`  out  DW  register-file write data.

## Operation
- **Read arbitration:** a round-robin arbiter over `rd_req`, driven by pointer `rd_ptr`.
  - The winner is the first requesting index at or after `rd_ptr`, modulo N_REQ.
  - On a grant to i: `rd_ptr` ← (i+1) mod N_REQ.
  - With no request, `rd_ptr` holds.
- **Write arbitration:** an identical, independent arbiter over `wr_req`, using `wr_ptr`.
- **Handshake:**
  - A requester holds `req` and its payload stable until it sees `gnt`.
  - `gnt` is combinational from `req` and the pointer.
  - A grant consumes exactly one request. To issue again, the requester keeps `req` high in the next cycle.
- **Read port mux:**
  - `rf_raddr0/1` carry the granted requester's `rd_addr0/1`.
  - When there is no read grant, they are 0.
- **Read response:**
  - A registered `rsp_id`/`rsp_vld` pair captures the grant at the clock edge.
  - `rd_rsp_valid` = `rsp_vld` ? onehot(`rsp_id`) : 0.
  - `rd_rsp_data0/1` pass through `rf_rdata0/1` combinationally.
  - When no response is valid, the data outputs are don't-care.
- **Write port mux:**
  - `rf_wen` = |`wr_gnt`.
  - `rf_waddr`/`rf_wdata` carry the granted requester's payload, and are 0 when idle.
- **Simultaneous events:**
  - A read and a write granted in the same cycle both proceed.
  - If they target the same register, the read response returns the newly written value. This follows from the register file latching the read address on the same edge as the write.
- **Write-after-write:** two writers to the same address never conflict, since only one write grant exists per cycle.

## Timing
- Grant latency: 0 cycles (combinational) when the requester is the highest-priority requester.
- Worst-case wait: N_REQ−1 cycles under full load. There is no starvation.
- Read data latency: exactly 1 cycle after `rd_gnt`.
  - Back-to-back reads are supported at full throughput, one per cycle.
- Write latency: the register contents update at the edge ending the grant cycle.
- **Reset** (asynchronous, active-low), effects while `rst_n` is low:
  - `rd_ptr` = `wr_ptr` = 0, so requester 0 has first priority.
  - `rsp_vld` = 0, so `rd_rsp_valid` = 0.
  - `rsp_id` = 0.
  - Combinational outputs follow their inputs: `rd_gnt`/`wr_gnt` may assert during reset if requests are present.
  - Requesters ignore grants while `rst_n` is low.
- **Reset mid-operation:** an in-flight read response is dropped (`rd_rsp_valid` falls immediately). The requester must reissue.

## Structure
- Shared package `regs_pkg`: `N_REQ`, `AW`, `DW` defaults, plus `onehot`/index helper function.
- Sub-module `rr_arbiter` (parameter `N`; ports `clk`, `rst_n`, `req`, `gnt`; internal pointer), instantiated twice: read and write.
- Top level: arbiters, payload muxes, response register.

## Test plan
1. **Reset and first grant:** `rst_n`=0, then release; `rd_req`=4'b1111 → `rd_gnt` = 0001, 0010, 0100, 1000, 0001 over consecutive cycles. `rd_rsp_valid` follows one cycle behind.
2. **Single read:** preload r5=16'h1234, r9=16'hBEEF; requester 2 reads (5,9) → `rd_gnt`=0100 in cycle N, then `rd_rsp_valid`=0100 with data0=1234 and data1=BEEF in cycle N+1.
3. **Write arbitration:**
   - Requesters 1 and 3 write r7 with 16'h0011 and 16'h0033 (`wr_ptr`=0) → requester 1 is granted first, then requester 3.
   - A subsequent read of r7 → 16'h0033.
4. **Same-cycle read and write:** requester 0 writes r4=16'hA5A5 while requester 1 reads r4 in the same cycle → the response next cycle is A5A5.
5. **Fairness:**
   - Requester 0 holds `rd_req` continuously; requester 3 raises its request once.
   - Requester 3 must be granted within 3 cycles, and no requester is granted twice before every other active requester has been granted.
6. **Mid-operation reset:** assert `rst_n`=0 in the cycle after a read grant → `rd_rsp_valid` drops to 0 immediately, and `rd_ptr` restarts at 0 after release.
